// File: rtl/cordic_pkg.sv
// Shared types and helpers for the CORDIC angle front end: quadrant decode,
// the fixed-point pi constant and the half-turn fold.
package cordic_pkg;

    localparam int unsigned CORDIC_W = 32;
    localparam logic [CORDIC_W-1:0] PI_Q = 32'd3373259426;

    typedef enum logic [1:0] {
        Q0 = 2'b00,
        Q1 = 2'b01,
        Q2 = 2'b10,
        Q3 = 2'b11
    } quadrant_t;

    typedef struct packed {
        logic                       neg;
        logic signed [CORDIC_W-1:0] bam_r;
    } fold_t;

    function automatic fold_t fold_bam(input logic [CORDIC_W-1:0] bam);
        fold_t     f;
        quadrant_t q;
        q     = quadrant_t'(bam[CORDIC_W-1 -: 2]);
        f.neg = (q == Q1) || (q == Q2);
        // Subtracting half a turn modulo 2^W only flips the top bit.
        f.bam_r = f.neg ? {~bam[CORDIC_W-1], bam[CORDIC_W-2:0]} : bam;
        return f;
    endfunction

endpackage

// File: rtl/cordic_flag_fifo.sv
// Small FIFO of 1-bit negate flags with a registered head output, so the
// consumer sees the oldest flag without a read-port mux in its path.
module cordic_flag_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     data_i,
    input  logic                     pop_i,
    output logic                     head_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [PTR_W:0]   count_q;
    logic             head_q;
    logic             push_en;
    logic             pop_en;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign count_o = count_q;
    assign head_o  = head_q;
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;

    // NOTE: storage carries no reset; only the pointers and head define validity.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_q] <= data_i;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            head_q  <= 1'b0;
        end else begin
            if (push_en) begin
                wr_q <= wr_q + PTR_W'(1);
            end
            if (pop_en) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
            // With one entry left, the next head is whatever is arriving now.
            if (pop_en) begin
                head_q <= (count_q == (PTR_W+1)'(1)) ? data_i : mem_q[rd_q + PTR_W'(1)];
            end else if (push_en && empty_o) begin
                head_q <= data_i;
            end
        end
    end

endmodule

// File: rtl/cordic_angle_reducer.sv
// Folds a full-circle BAM angle into [-pi/2, pi/2), scales it to Q2 radians
// for the CORDIC core, and queues the matching result-negate flags.
module cordic_angle_reducer #(
    parameter int BIT_WIDTH       = 32,
    parameter int LOG_2_BIT_WIDTH = 5,
    parameter int FLAG_DEPTH      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BIT_WIDTH-1:0]          in_angle,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [BIT_WIDTH-1:0]   out_angle,
    input  logic                          flag_pop,
    output logic                          flag_negate,
    output logic                          flag_empty,
    output logic                          flag_full,
    output logic [$clog2(FLAG_DEPTH):0]   flag_count
);

    import cordic_pkg::*;

    localparam int PROD_W     = 2*BIT_WIDTH + 1;
    localparam int FRAC_SHIFT = (1 << LOG_2_BIT_WIDTH) - 1;
    localparam logic signed [PROD_W-1:0] ROUND = PROD_W'(1) << (BIT_WIDTH-2);

    fold_t                        s1_d;
    fold_t                        s1_q;
    logic                         s1_valid_q;
    logic                         s2_valid_q;
    logic                         s2_neg_q;
    logic signed [BIT_WIDTH-1:0]  out_angle_d;
    logic signed [BIT_WIDTH-1:0]  out_angle_q;
    logic signed [PROD_W-1:0]     bam_ext;
    logic signed [PROD_W-1:0]     pi_ext;
    logic                         fire;
    logic                         advance;

    assign out_valid = s2_valid_q & ~flag_full;
    assign fire      = out_valid & out_ready;
    assign advance   = ~s2_valid_q | fire;
    assign in_ready  = ~s1_valid_q | advance;
    assign out_angle = out_angle_q;

    // NOTE: every always_comb output is assigned on all paths, so no latch is inferred.
    always_comb begin
        s1_d        = fold_bam(in_angle);
        bam_ext     = {{(BIT_WIDTH+1){s1_q.bam_r[BIT_WIDTH-1]}}, s1_q.bam_r};
        pi_ext      = {{(BIT_WIDTH+1){1'b0}}, PI_Q};
        out_angle_d = BIT_WIDTH'((bam_ext * pi_ext + ROUND) >>> FRAC_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            s2_valid_q  <= 1'b0;
            s2_neg_q    <= 1'b0;
            out_angle_q <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_d;
                end
            end
            if (advance) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_angle_q <= out_angle_d;
                    s2_neg_q    <= s1_q.neg;
                end
            end
        end
    end

    cordic_flag_fifo #(
        .DEPTH (FLAG_DEPTH)
    ) u_flag_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fire),
        .data_i  (s2_neg_q),
        .pop_i   (flag_pop),
        .head_o  (flag_negate),
        .empty_o (flag_empty),
        .full_o  (flag_full),
        .count_o (flag_count)
    );

endmodule

// File: tb/tb_cordic_angle_reducer.sv
// Self-checking bench for cordic_angle_reducer: fixed reduction table, directed
// corner sequences, and a randomized run scored against an arithmetic model.
module tb_cordic_angle_reducer;

    localparam int W = 32;
    localparam int D = 8;
    localparam longint PI_Q    = 64'sd3373259426;
    localparam longint TURN    = 64'sh1_0000_0000;
    localparam longint HALF    = 64'sh8000_0000;
    localparam longint QUARTER = 64'sh4000_0000;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [W-1:0]        in_angle;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_angle;
    logic                flag_pop;
    logic                flag_negate;
    logic                flag_empty;
    logic                flag_full;
    logic [3:0]          flag_count;

    always #5 clk = ~clk;

    cordic_angle_reducer #(
        .BIT_WIDTH       (W),
        .LOG_2_BIT_WIDTH (5),
        .FLAG_DEPTH      (D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_angle    (in_angle),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_angle   (out_angle),
        .flag_pop    (flag_pop),
        .flag_negate (flag_negate),
        .flag_empty  (flag_empty),
        .flag_full   (flag_full),
        .flag_count  (flag_count)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        longint angle;
        bit     neg;
    } exp_t;

    typedef struct {
        logic [W-1:0] angle;
        longint       out;
        bit           neg;
    } vec_t;

    exp_t exp_q[$];
    bit   flag_q[$];
    bit   mon_on = 1'b0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: fold by quadrant, then round-half-up of bam * pi / 2^31.
    function automatic exp_t ref_reduce(input logic [W-1:0] a);
        exp_t   e;
        longint b;
        longint num;
        int     quad;
        quad  = int'(a[W-1:W-2]);
        b     = longint'(a);
        e.neg = (quad == 1) || (quad == 2);
        if (e.neg) b = b - HALF;
        else if (b >= HALF) b = b - TURN;
        num     = b * PI_Q + QUARTER;
        e.angle = num / HALF;
        if ((num % HALF) != 0 && num < 0) e.angle = e.angle - 1;
        return e;
    endfunction

    // Scoreboard: observe state mid-cycle, then apply what the next edge does.
    always @(negedge clk) begin : monitor
        exp_t e;
        bit   fired;
        fired = 1'b0;
        e     = '{angle: 0, neg: 1'b0};
        if (reset) begin
            exp_q.delete();
            flag_q.delete();
        end else if (mon_on) begin
            check("flag_count", flag_count, flag_q.size());
            check("flag_empty", flag_empty, flag_q.size() == 0);
            check("flag_full", flag_full, flag_q.size() == D);
            if (flag_q.size() > 0) check("flag_negate_head", flag_negate, flag_q[0]);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_valid_unexpected", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_angle_model", out_angle, e.angle);
                    fired = 1'b1;
                end
            end
            if (flag_pop && flag_q.size() > 0) void'(flag_q.pop_front());
            if (fired) flag_q.push_back(e.neg);
            if (in_valid && in_ready) exp_q.push_back(ref_reduce(in_angle));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_angle = a;
        for (int n = 0; n < 20 && !acc; n++) begin
            #1;
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("send_accepted", acc, 1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flag_pop  = 1'b1;
        repeat (20) tick();
        flag_pop = 1'b0;
        check("drain_samples", exp_q.size(), 0);
        check("drain_flags", flag_count, 0);
    endtask

    task automatic wait_count(input int target);
        for (int n = 0; n < 30 && flag_count != 4'(target); n++) tick();
        check("wait_flag_count", flag_count, target);
    endtask

    vec_t                tbl[8];
    logic [W-1:0]        corners[8];
    logic signed [W-1:0] held_angle;
    int                  hold_cycles;
    bit                  saw_low;
    bit                  acc;
    bit                  exp_head;
    int                  idx;

    initial begin
        tbl[0] = '{32'h2000_0000,  843314857, 1'b0};
        tbl[1] = '{32'h6000_0000, -843314856, 1'b1};
        tbl[2] = '{32'h8000_0000,          0, 1'b1};
        tbl[3] = '{32'hC000_0000, -1686629713, 1'b0};
        tbl[4] = '{32'h0000_0000,          0, 1'b0};
        tbl[5] = '{32'h4000_0000, -1686629713, 1'b1};
        tbl[6] = '{32'h3FFF_FFFF, 1686629711, 1'b0};
        tbl[7] = '{32'hFFFF_FFFF,         -2, 1'b0};
        corners = '{32'h0, 32'h3FFF_FFFF, 32'h4000_0000, 32'h7FFF_FFFF,
                    32'h8000_0000, 32'hBFFF_FFFF, 32'hC000_0000, 32'hFFFF_FFFF};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_angle  = '0;
        out_ready = 1'b1;
        flag_pop  = 1'b0;
        repeat (2) tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_angle", out_angle, 0);
        check("rst_flag_empty", flag_empty, 1);
        check("rst_flag_full", flag_full, 0);
        check("rst_flag_count", flag_count, 0);
        check("rst_flag_negate", flag_negate, 0);
        reset  = 1'b0;
        mon_on = 1'b1;

        // Reduction table with exact two-cycle latency and flag at pop.
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].angle);
            tick();
            check("tbl_out_valid", out_valid, 1);
            check("tbl_out_angle", out_angle, tbl[i].out);
            tick();
            check("tbl_flag_negate", flag_negate, tbl[i].neg);
            check("tbl_flag_count", flag_count, 1);
            flag_pop = 1'b1;
            tick();
            flag_pop = 1'b0;
            check("tbl_flag_empty", flag_empty, 1);
        end

        // Backpressure: 10 samples, out_ready low for 5 cycles.
        flag_pop    = 1'b1;
        idx         = 0;
        hold_cycles = 0;
        saw_low     = 1'b0;
        held_angle  = '0;
        for (int cyc = 0; cyc < 100 && idx < 10; cyc++) begin
            out_ready = !(cyc >= 3 && cyc < 8);
            in_valid  = 1'b1;
            in_angle  = 32'h1999_9999 * idx + 32'd77;
            #1;
            acc = in_ready;
            if (!in_ready) saw_low = 1'b1;
            if (out_valid && !out_ready) begin
                if (hold_cycles > 0) check("bp_hold_angle", out_angle, held_angle);
                else held_angle = out_angle;
                hold_cycles++;
            end
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check("bp_all_sent", idx, 10);
        check("bp_in_ready_dropped", saw_low, 1);
        check("bp_hold_cycles", hold_cycles, 5);
        drain();

        // FIFO full gates the ninth sample until one flag is popped.
        for (int i = 0; i < 9; i++) send(32'h1F00_0000 * i);
        for (int n = 0; n < 20 && !flag_full; n++) tick();
        check("full_flag_full", flag_full, 1);
        check("full_flag_count", flag_count, 8);
        check("full_out_gated", out_valid, 0);
        tick();
        tick();
        check("full_out_still_gated", out_valid, 0);
        flag_pop = 1'b1;
        tick();
        flag_pop = 1'b0;
        check("full_reopen_valid", out_valid, 1);
        check("full_after_pop_count", flag_count, 7);
        tick();
        check("full_refill_count", flag_count, 8);
        drain();

        // Simultaneous push and pop at count 3.
        send(32'h2000_0000);
        send(32'h6000_0000);
        send(32'h1000_0000);
        wait_count(3);
        out_ready = 1'b0;
        send(32'hA000_0000);
        for (int n = 0; n < 10 && !out_valid; n++) tick();
        check("pp_pre_count", flag_count, 3);
        check("pp_pre_valid", out_valid, 1);
        exp_head  = flag_q[1];
        out_ready = 1'b1;
        flag_pop  = 1'b1;
        tick();
        flag_pop = 1'b0;
        check("pp_count_same", flag_count, 3);
        check("pp_head_advanced", flag_negate, exp_head);
        drain();

        // Pop while empty is ignored.
        flag_pop = 1'b1;
        tick();
        flag_pop = 1'b0;
        check("pe_flag_empty", flag_empty, 1);
        check("pe_flag_count", flag_count, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_angle  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 7)] : $urandom;
            out_ready = ($urandom_range(0, 9) < 8);
            flag_pop  = ($urandom_range(0, 2) == 0);
            tick();
        end
        drain();

        // Reset mid-stream with both stages full and four flags queued.
        send(32'h0800_0000);
        send(32'h4800_0000);
        send(32'h8800_0000);
        send(32'hC800_0000);
        wait_count(4);
        out_ready = 1'b0;
        send(32'h1234_5678);
        send(32'h9876_5432);
        check("mr_pre_out_valid", out_valid, 1);
        reset = 1'b1;
        tick();
        check("mr_out_valid", out_valid, 0);
        check("mr_flag_count", flag_count, 0);
        check("mr_in_ready", in_ready, 1);
        check("mr_out_angle", out_angle, 0);
        reset     = 1'b0;
        out_ready = 1'b1;
        send(32'hC000_0000);
        tick();
        check("mr_latency_valid", out_valid, 1);
        check("mr_latency_angle", out_angle, -1686629713);
        tick();
        check("mr_flag_negate", flag_negate, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cordic_angle_reducer.md
# cordic_angle_reducer

Front-end stage for the CORDIC cosine/sine cores. It takes a full-circle binary angle (BAM), folds it into the core's convergence range [-pi/2, pi/2), and converts it to signed Q2.(BIT_WIDTH-2) radians for the core's `angle` input. It keeps a FIFO of per-sample negate flags. The downstream output stage pops one flag per core `done` and applies the sign correction, so the full ±pi circle is covered.

## Interface
- `BIT_WIDTH`, 32: angle and data width.
- `LOG_2_BIT_WIDTH`, 5: log2 of `BIT_WIDTH`.
- `FLAG_DEPTH`, 8: negate-flag FIFO depth; must be a power of two, ≥2.
- `PI_Q`, 32'd3373259426: round(pi·2^(BIT_WIDTH-2)), unsigned.
- `clk` in 1: clock; all logic on posedge.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `in_valid` in 1: `in_angle` valid.
- `in_ready` out 1: stage can accept.
- `in_angle` in `BIT_WIDTH`: unsigned BAM; 2^BIT_WIDTH = 2pi; 0 = 0 rad.
- `out_valid` out 1: `out_angle` valid; drives core `start`.
- `out_ready` in 1: core `ready`.
- `out_angle` out `BIT_WIDTH` signed: reduced angle, Q2.(BIT_WIDTH-2) radians.
- `flag_pop` in 1: remove head flag; tied to core `done`.
- `flag_negate` out 1: head flag, 1 means the result must be negated.
- `flag_empty` out 1: FIFO empty.
- `flag_full` out 1: FIFO full.
- `flag_count` out `$clog2(FLAG_DEPTH)+1`: FIFO occupancy.

## Operation
- **Fold (stage S1).** The quadrant is `in_angle[W-1:W-2]`.
  - Quadrants 00 and 11: `bam_r = in_angle` taken as signed, `neg = 0`.
  - Quadrants 01 and 10: `bam_r = in_angle - 2^(W-1)` modulo 2^W, taken as signed, `neg = 1`. This uses the identity cos(θ) = -cos(θ-pi), and the same holds for sin.
  - `bam_r` always lies in [-2^(W-2), 2^(W-2)).
- **Scale (stage S2).**
  - `out_angle = (bam_r · PI_Q + 2^(W-2)) >>> (W-1)`.
  - The product is signed, 2W+1 bits, with `PI_Q` zero-extended.
  - The shift is arithmetic, so rounding is round-half-up toward +inf.
  - No saturation is needed; the result magnitude is at most round(pi/2·2^(W-2)).
- **Output handshake.**
  - `out_valid = s2_valid & ~flag_full`.
  - The transfer fires on `out_valid & out_ready`, and the same edge pushes S2's `neg` into the FIFO.
- **Pipeline advance.**
  - `advance = ~s2_valid | fire`.
  - S1→S2 and input→S1 move only on `advance`, with bubbles collapsed. S1 loads when it is empty or moving.
  - `in_ready = ~s1_valid | advance`.
- **FIFO pop.**
  - `flag_pop` while empty is ignored; no state changes.
  - Push and pop in the same cycle leave the count unchanged.
  - Pop while full is allowed and reopens `out_valid` on the next cycle.
- **Reset.**
  - Clears `s1_valid`, `s2_valid`, the FIFO pointers and `out_angle`.
  - Reset values: `in_ready` 1, `out_valid` 0, `out_angle` 0, `flag_empty` 1, `flag_full` 0, `flag_count` 0, `flag_negate` 0.
  - Reset mid-operation drops all in-flight samples and flags.

## Timing
- **Latency.** A sample accepted at edge k sits in S1 after k and in S2 after k+1. `out_valid` is high in the cycle after edge k+1, unless the FIFO is full or the pipeline is stalled.
- **Throughput.** One sample per cycle when `out_ready` stays high and the FIFO is not full.
- **Output stability.** `out_angle` and `out_valid` hold stable while `out_valid & ~out_ready`.
- **Flag visibility.** `flag_negate` is registered head data. It is valid in the cycle after the push that made the FIFO non-empty.
- **Combinational paths.**
  - `out_ready` → `in_ready` is permitted.
  - There is no other combinational path from input to output.

## Structure
- **Package `cordic_pkg`.**
  - `PI_Q` localparam.
  - `quadrant_t` enum: Q0=2'b00, Q1=2'b01, Q2=2'b10, Q3=2'b11.
  - Function `fold_bam(bam) -> {neg, bam_r}`.
- **Sub-module `cordic_flag_fifo`.**
  - Parameterised on depth, 1-bit data, synchronous reset.
  - Push, pop, empty, full and count.
  - Registered head output.

## Test plan
- **Reduction values** (W=32): each reduced angle followed by its `flag_negate` at pop.
  - `in_angle` 0x2000_0000 → `out_angle` 843314857, negate 0.
  - 0x6000_0000 → -843314856, negate 1.
  - 0x8000_0000 → 0, negate 1.
  - 0xC000_0000 → -1686629713, negate 0.
- **Backpressure.**
  - Stimulus: stream of 10 angles with `out_ready` 0 for 5 cycles.
  - Required: `out_angle` stable while held, `in_ready` drops after S1 and S2 fill, no sample lost or duplicated, output order matches input order.
- **FIFO full.**
  - Stimulus: `out_ready`=1, `flag_pop`=0, push 8 samples.
  - Required: `flag_full`=1, `out_valid` gated low for sample 9.
  - Stimulus: one `flag_pop`.
  - Required: sample 9 transfers on the following cycle, `flag_count` returns to 8.
- **Simultaneous push and pop** at count 3: count stays 3, head advances.
- **Pop while empty:** no change, `flag_empty` stays 1.
- **Reset mid-stream:** assert `reset` with S1 and S2 valid and 4 flags queued. Required: next cycle `out_valid`=0, `flag_count`=0, `in_ready`=1; a sample issued afterward appears with 2-cycle latency.
